nibble_serial_add_ctrl: RTL

Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. It takes operands through a valid/ready input handshake and holds the result under a valid/ready output handshake. It sits between operand producers and result consumers wherever a full-width adder is too costly and multi-cycle latency is acceptable.

---
 rtl/nibble_serial_add_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_serial_add_ctrl: WIDTH-bit add/subtract on one 4-bit slice, LSB   |
// | nibble first, with valid/ready handshakes.        Revision: 1.0          |
// +--------------------------------------------------------------------------+
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [4:0]       slice_res;

  // The only adder in the design: one nibble plus the registered carry.
  always_comb begin
    slice_a   = opa_q[{idx_q, 2'b00} +: 4];
    slice_b   = opb_q[{idx_q, 2'b00} +: 4];
    slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_q};
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = in_a;
          opb_d   = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice_res[3:0];
        carry_d = slice_res[4];
        if (idx_q == LAST_IDX) begin
          // idx parks on the last nibble; it is cleared on the next accept.
          cout_d  = slice_res[4];
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (slice_res[3] != opa_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire
